// File: rtl/mac_result_drain.sv
// mac_result_drain
//   Terminates the non-stallable MAC pipeline. Upstream may issue a non-NOP
//   operation only when granted a credit. Every result that leaves the MAC
//   NOP pipeline (nop_in=0) is captured in a small FIFO. The FIFO head is
//   presented on a valid/ready port. A credit is returned on every pop.
//
//   Optional feature: define MAC_DRAIN_OVF_EN to get a sticky overflow
//   register. Without it, overflow is tied to 0, and a push into a full FIFO
//   is still dropped silently.
//
// Ports
//   clk        clock, all state updates on posedge
//   sclr_n     synchronous active-low reset
//   issue_req  upstream wants to issue one non-NOP operation
//   issue_gnt  issue permitted this cycle (combinational)
//   nop_in     1 = no result this cycle from the MAC NOP pipeline
//   res_in     MAC result, qualified by nop_in==0
//   out_valid  FIFO head holds a result
//   out_ready  downstream accepts the head
//   out_data   FIFO head data (registered array, no path from res_in)
//   count      FIFO occupancy, 0..DEPTH
//   credits    issue credits remaining, 0..DEPTH
//   overflow   sticky: push into a full FIFO without a simultaneous pop
module mac_result_drain #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             sclr_n,
    input  logic             issue_req,
    output logic             issue_gnt,
    input  logic             nop_in,
    input  logic [WIDTH-1:0] res_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    count,
    output logic [CW-1:0]    credits,
    output logic             overflow
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    credits_q;

    logic push;
    logic push_acc;
    logic pop;
    logic full;

    assign out_valid = (count_q != '0);
    assign pop       = out_valid & out_ready;
    assign full      = (count_q == CW'(DEPTH));
    assign push      = ~nop_in;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is
    // accepted then.
    assign push_acc  = push & (~full | pop);

    assign issue_gnt = sclr_n & issue_req & (credits_q != '0);

    assign out_data  = mem[rd_ptr];
    assign count     = count_q;
    assign credits   = credits_q;

    always_ff @(posedge clk) begin
        if (!sclr_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_q   <= '0;
            credits_q <= CW'(DEPTH);
            // The array is cleared so that out_data reads 0 until the first push.
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_acc) begin
                mem[wr_ptr] <= res_in;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end

            case ({push_acc, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase

            // Saturating in both directions. This guards against pops that
            // occur without a matching grant, such as an upstream that ignores
            // issue_gnt.
            if (issue_gnt && !pop) begin
                if (credits_q != '0) begin
                    credits_q <= credits_q - CW'(1);
                end
            end else if (pop && !issue_gnt) begin
                if (credits_q != CW'(DEPTH)) begin
                    credits_q <= credits_q + CW'(1);
                end
            end
        end
    end

`ifdef MAC_DRAIN_OVF_EN
    logic ovf_q;

    always_ff @(posedge clk) begin
        if (!sclr_n) begin
            ovf_q <= 1'b0;
        end else if (push && full && !pop) begin
            ovf_q <= 1'b1;
        end
    end

    assign overflow = ovf_q;
`else
    assign overflow = 1'b0;
`endif

endmodule
